i2s_frame_ctrl: RTL and testbench

- Master-mode I2S sequencer for the codec audio path.
- Generates BCLK/LRCK from the system clock and drives the enable/shift controls of one PISO transmit register and one SIPO receive register.
- Exchanges stereo sample pairs with the DSP side: transmit uses a valid/ready handshake, receive is a one-cycle valid pulse.
- Sits between the sample-processing logic and the two shift registers; it contains no datapath shifting itself.

---
 rtl/i2s_pkg.sv | 17 +
 rtl/i2s_bclk_gen.sv | 54 +++++
 rtl/i2s_frame_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_i2s_frame_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared types and defaults for the I2S frame controller.
package i2s_pkg;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } chan_e;

    // PISO mode select values presented on piso_wren_o
    localparam logic PISO_LOAD  = 1'b0;
    localparam logic PISO_SHIFT = 1'b1;

    localparam int unsigned DEF_WD       = 24;
    localparam int unsigned DEF_SLOT_W   = 32;
    localparam int unsigned DEF_BCLK_DIV = 4;

endpackage

// File: rtl/i2s_bclk_gen.sv
// BCLK divider: toggles bclk_o every BCLK_DIV system clocks and flags the
// cycle in which the falling or rising BCLK edge will take effect.
module i2s_bclk_gen
    import i2s_pkg::*;
#(
    parameter int unsigned BCLK_DIV = DEF_BCLK_DIV
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    output logic bclk_o,
    output logic fall_evt_o,
    output logic rise_evt_o
);

    localparam int unsigned CW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(BCLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          bclk_q, bclk_d;
    logic          tc;

    // Divider next state; events are asserted during the terminal-count cycle
    always_comb begin
        tc     = en_i && (cnt_q == CNT_MAX);
        cnt_d  = cnt_q;
        bclk_d = bclk_q;
        if (!en_i) begin
            cnt_d  = '0;
            bclk_d = 1'b0;
        end else if (tc) begin
            cnt_d  = '0;
            bclk_d = ~bclk_q;
        end else begin
            cnt_d  = cnt_q + CW'(1);
        end
        fall_evt_o = tc && bclk_q;
        rise_evt_o = tc && !bclk_q;
    end

    // Divider registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            bclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            bclk_q <= bclk_d;
        end
    end

    assign bclk_o = bclk_q;

endmodule

// File: rtl/i2s_frame_ctrl.sv
// Master-mode I2S sequencer: slot counter, LRCK, PISO/SIPO strobes and the
// DSP-side transmit holding buffer / receive pair outputs.
module i2s_frame_ctrl
    import i2s_pkg::*;
#(
    parameter int unsigned WD       = DEF_WD,
    parameter int unsigned SLOT_W   = DEF_SLOT_W,
    parameter int unsigned BCLK_DIV = DEF_BCLK_DIV
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          en_i,
    output logic          bclk_o,
    output logic          lrck_o,
    output logic          dacdat_o,
    input  logic          piso_sdata_i,
    output logic          piso_en_o,
    output logic          piso_wren_o,
    output logic [WD-1:0] piso_pdata_o,
    output logic          sipo_en_o,
    output logic          sipo_wren_o,
    input  logic [WD-1:0] sipo_pdata_i,
    input  logic [WD-1:0] tx_left_i,
    input  logic [WD-1:0] tx_right_i,
    input  logic          tx_valid_i,
    output logic          tx_ready_o,
    output logic          tx_underrun_o,
    output logic [WD-1:0] rx_left_o,
    output logic [WD-1:0] rx_right_o,
    output logic          rx_valid_o
);

    localparam int unsigned BW = $clog2(SLOT_W);
    localparam logic [BW-1:0] B_LAST = BW'(SLOT_W - 1);
    localparam logic [BW-1:0] B_ONE  = BW'(1);
    localparam logic [BW-1:0] B_TWO  = BW'(2);
    localparam logic [BW-1:0] B_WD   = BW'(WD);
    localparam logic [BW-1:0] B_CAP  = BW'(WD + 1);

    logic          fall_evt, rise_evt;

    logic [BW-1:0] b_q, b_d, b_next;
    chan_e         lrck_q, lrck_d;
    logic          dacdat_q, dacdat_d;
    logic          run_q, run_d;
    logic [WD-1:0] left_hold_q, left_hold_d;
    logic [WD-1:0] rx_left_q, rx_left_d;
    logic [WD-1:0] rx_right_q, rx_right_d;
    logic          rx_valid_q, rx_valid_d;
    logic          underrun_q, underrun_d;

    logic          buf_full_q, buf_full_d;
    logic [WD-1:0] buf_left_q, buf_left_d;
    logic [WD-1:0] buf_right_q, buf_right_d;
    logic [WD-1:0] shadow_q, shadow_d;

    logic          load_evt, shift_evt, cap_evt, in_word, left_load, xfer;

    i2s_bclk_gen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_bclk_gen (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .en_i       (en_i),
        .bclk_o     (bclk_o),
        .fall_evt_o (fall_evt),
        .rise_evt_o (rise_evt)
    );

    // Event decode: strobes refer to the slot bit being entered on a falling edge
    always_comb begin
        b_next    = (b_q == B_LAST) ? '0 : b_q + B_ONE;
        load_evt  = fall_evt && (b_next == B_ONE);
        shift_evt = fall_evt && (b_next >= B_TWO) && (b_next <= B_WD);
        cap_evt   = fall_evt && (b_next == B_CAP);
        in_word   = (b_q >= B_ONE) && (b_q <= B_WD);
        left_load = load_evt && (lrck_q == CH_LEFT);
        xfer      = tx_valid_i && !buf_full_q;
    end

    // Shift-register strobes and parallel word selection
    always_comb begin
        piso_en_o    = load_evt || shift_evt;
        piso_wren_o  = shift_evt ? PISO_SHIFT : PISO_LOAD;
        sipo_en_o    = rise_evt && in_word;
        if (lrck_q == CH_LEFT) begin
            piso_pdata_o = buf_full_q ? buf_left_q : '0;
        end else begin
            piso_pdata_o = shadow_q;
        end
    end

    // Slot counter, LRCK, serial data and receive pair next state
    always_comb begin
        b_d         = b_q;
        lrck_d      = lrck_q;
        dacdat_d    = 1'b0;
        run_d       = en_i;
        left_hold_d = left_hold_q;
        rx_left_d   = rx_left_q;
        rx_right_d  = rx_right_q;
        rx_valid_d  = 1'b0;
        underrun_d  = 1'b0;
        if (!en_i) begin
            b_d         = B_LAST;
            lrck_d      = CH_RIGHT;
            left_hold_d = '0;
            rx_left_d   = '0;
            rx_right_d  = '0;
        end else begin
            if (fall_evt) begin
                b_d = b_next;
                if (b_q == B_LAST) begin
                    lrck_d = (lrck_q == CH_LEFT) ? CH_RIGHT : CH_LEFT;
                end
            end
            dacdat_d   = in_word ? piso_sdata_i : 1'b0;
            underrun_d = left_load && !buf_full_q;
            if (cap_evt) begin
                if (lrck_q == CH_LEFT) begin
                    left_hold_d = sipo_pdata_i;
                end else begin
                    rx_left_d  = left_hold_q;
                    rx_right_d = sipo_pdata_i;
                    rx_valid_d = 1'b1;
                end
            end
        end
    end

    // Holding buffer: independent of en_i; a same-cycle consume sees the old contents
    always_comb begin
        buf_full_d  = buf_full_q;
        buf_left_d  = buf_left_q;
        buf_right_d = buf_right_q;
        shadow_d    = shadow_q;
        if (left_load) begin
            shadow_d   = buf_full_q ? buf_right_q : '0;
            buf_full_d = 1'b0;
        end
        if (xfer) begin
            buf_full_d  = 1'b1;
            buf_left_d  = tx_left_i;
            buf_right_d = tx_right_i;
        end
    end

    // State registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            b_q         <= B_LAST;
            lrck_q      <= CH_RIGHT;
            dacdat_q    <= 1'b0;
            run_q       <= 1'b0;
            left_hold_q <= '0;
            rx_left_q   <= '0;
            rx_right_q  <= '0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            buf_full_q  <= 1'b0;
            buf_left_q  <= '0;
            buf_right_q <= '0;
            shadow_q    <= '0;
        end else begin
            b_q         <= b_d;
            lrck_q      <= lrck_d;
            dacdat_q    <= dacdat_d;
            run_q       <= run_d;
            left_hold_q <= left_hold_d;
            rx_left_q   <= rx_left_d;
            rx_right_q  <= rx_right_d;
            rx_valid_q  <= rx_valid_d;
            underrun_q  <= underrun_d;
            buf_full_q  <= buf_full_d;
            buf_left_q  <= buf_left_d;
            buf_right_q <= buf_right_d;
            shadow_q    <= shadow_d;
        end
    end

    assign lrck_o        = lrck_q;
    assign dacdat_o      = dacdat_q;
    assign sipo_wren_o   = run_q;
    assign tx_ready_o    = !buf_full_q;
    assign tx_underrun_o = underrun_q;
    assign rx_left_o     = rx_left_q;
    assign rx_right_o    = rx_right_q;
    assign rx_valid_o    = rx_valid_q;

endmodule

// File: tb/tb_i2s_frame_ctrl.sv
// Bench for i2s_frame_ctrl with behavioural PISO/SIPO registers and the ADC
// line looped back from dacdat_o; expected slots/pairs/underruns are queued
// by the stimulus and consumed by independent monitors.
module tb_i2s_frame_ctrl;
    import i2s_pkg::*;

    localparam int unsigned WD       = 16;
    localparam int unsigned SLOT_W   = 32;
    localparam int unsigned BCLK_DIV = 2;

    logic          clk = 1'b0;
    logic          rst_ni, en_i;
    logic          bclk_o, lrck_o, dacdat_o;
    logic          piso_sdata, piso_en_o, piso_wren_o;
    logic [WD-1:0] piso_pdata_o;
    logic          sipo_en_o, sipo_wren_o;
    logic [WD-1:0] sipo_pdata;
    logic [WD-1:0] tx_left, tx_right;
    logic          tx_valid, tx_ready_o, tx_underrun_o;
    logic [WD-1:0] rx_left_o, rx_right_o;
    logic          rx_valid_o;

    always #5 clk = ~clk;

    i2s_frame_ctrl #(
        .WD       (WD),
        .SLOT_W   (SLOT_W),
        .BCLK_DIV (BCLK_DIV)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .en_i          (en_i),
        .bclk_o        (bclk_o),
        .lrck_o        (lrck_o),
        .dacdat_o      (dacdat_o),
        .piso_sdata_i  (piso_sdata),
        .piso_en_o     (piso_en_o),
        .piso_wren_o   (piso_wren_o),
        .piso_pdata_o  (piso_pdata_o),
        .sipo_en_o     (sipo_en_o),
        .sipo_wren_o   (sipo_wren_o),
        .sipo_pdata_i  (sipo_pdata),
        .tx_left_i     (tx_left),
        .tx_right_i    (tx_right),
        .tx_valid_i    (tx_valid),
        .tx_ready_o    (tx_ready_o),
        .tx_underrun_o (tx_underrun_o),
        .rx_left_o     (rx_left_o),
        .rx_right_o    (rx_right_o),
        .rx_valid_o    (rx_valid_o)
    );

    // External shift registers
    logic [WD-1:0] piso_reg = '0;
    logic [WD-1:0] sipo_reg = '0;
    always @(posedge clk) begin
        if (piso_en_o)
            piso_reg <= (piso_wren_o == PISO_LOAD) ? piso_pdata_o : {piso_reg[WD-2:0], 1'b0};
        if (sipo_en_o && sipo_wren_o)
            sipo_reg <= {sipo_reg[WD-2:0], dacdat_o};
    end
    assign piso_sdata = piso_reg[WD-1];
    assign sipo_pdata = sipo_reg;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
    endtask

    logic [SLOT_W-1:0] exp_dac[$];
    logic [2*WD-1:0]   exp_rx[$];
    int                exp_ur[$];

    function automatic logic [SLOT_W-1:0] slot_of(input logic [WD-1:0] w);
        logic [SLOT_W-1:0] s;
        s = '0;
        s[SLOT_W-2 -: WD] = w;
        return s;
    endfunction

    task automatic exp_frame(input logic [WD-1:0] l, input logic [WD-1:0] r, input bit ur);
        exp_dac.push_back(slot_of(l));
        exp_dac.push_back(slot_of(r));
        exp_rx.push_back({l, r});
        if (ur) exp_ur.push_back(1);
    endtask

    // Monitor: serial slots, BCLK period and LRCK spacing
    int                cyc = 0, last_rise = 0, last_lt = 0, bidx = 0;
    bit                active = 0, br_valid = 0, lt_valid = 0;
    logic              pb = 1'b0, pl = 1'b1;
    logic [SLOT_W-1:0] slot = '0;
    always @(negedge clk) begin
        cyc++;
        if (!rst_ni || !en_i) begin
            active   = 0;
            br_valid = 0;
            lt_valid = 0;
        end else begin
            if (bclk_o && !pb) begin
                if (br_valid) check("bclk_period", 64'(cyc - last_rise), 64'(2 * BCLK_DIV));
                br_valid  = 1;
                last_rise = cyc;
                if (active && bidx < int'(SLOT_W)) slot[SLOT_W-1-bidx] = dacdat_o;
            end
            if (lrck_o != pl) begin
                if (lt_valid) check("lrck_interval", 64'(cyc - last_lt), 64'(2 * BCLK_DIV * SLOT_W));
                lt_valid = 1;
                last_lt  = cyc;
                if (active) begin
                    check("dac_slot_expected", 64'(exp_dac.size() != 0), 64'(1));
                    if (exp_dac.size() != 0) check("dac_slot", 64'(slot), 64'(exp_dac.pop_front()));
                end
                active = 1;
                bidx   = 0;
                slot   = '0;
            end else if (!bclk_o && pb && active) begin
                bidx++;
            end
        end
        pb = bclk_o;
        pl = lrck_o;
    end

    // Monitor: receive pairs and underrun pulses
    always @(negedge clk) begin
        if (rx_valid_o) begin
            check("rx_valid_expected", 64'(exp_rx.size() != 0), 64'(1));
            if (exp_rx.size() != 0) check("rx_pair", 64'({rx_left_o, rx_right_o}), 64'(exp_rx.pop_front()));
        end
        if (tx_underrun_o) begin
            check("underrun_expected", 64'(exp_ur.size() != 0), 64'(1));
            if (exp_ur.size() != 0) void'(exp_ur.pop_front());
            check("underrun_in_left_slot", 64'(lrck_o), 64'(0));
        end
    end

    // Handshake / ready-cycle counters, cleared by the stimulus per frame
    int hs_cnt = 0, rdy_cnt = 0;
    always @(posedge clk) begin
        if (rst_ni) begin
            if (tx_valid && tx_ready_o) hs_cnt++;
            if (tx_ready_o) rdy_cnt++;
        end
    end

    task automatic check_idle(input string tag);
        check({tag, "_bclk"},     64'(bclk_o),        64'(0));
        check({tag, "_lrck"},     64'(lrck_o),        64'(1));
        check({tag, "_dacdat"},   64'(dacdat_o),      64'(0));
        check({tag, "_piso_en"},  64'(piso_en_o),     64'(0));
        check({tag, "_sipo_en"},  64'(sipo_en_o),     64'(0));
        check({tag, "_rx_valid"}, 64'(rx_valid_o),    64'(0));
        check({tag, "_rx_left"},  64'(rx_left_o),     64'(0));
        check({tag, "_rx_right"}, 64'(rx_right_o),    64'(0));
        check({tag, "_underrun"}, 64'(tx_underrun_o), 64'(0));
    endtask

    task automatic wait_lrck(input logic want, input string tag);
        logic p;
        bit   ok;
        ok = 0;
        @(negedge clk);
        p = lrck_o;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            if (p != want && lrck_o == want) begin
                ok = 1;
                break;
            end
            p = lrck_o;
        end
        check(tag, 64'(ok), 64'(1));
    endtask

    task automatic push_pair(input logic [WD-1:0] l, input logic [WD-1:0] r);
        bit ok;
        ok       = 0;
        tx_left  = l;
        tx_right = r;
        tx_valid = 1'b1;
        for (int n = 0; n < 600; n++) begin
            if (tx_ready_o) begin
                ok = 1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        tx_valid = 1'b0;
        check("tx_accept", 64'(ok), 64'(1));
        check("tx_ready_after_fill", 64'(tx_ready_o), 64'(0));
    endtask

    task automatic check_first_fall(input string tag);
        repeat (3) @(negedge clk);
        check({tag, "_lrck_before"}, 64'(lrck_o), 64'(1));
        check({tag, "_bclk_before"}, 64'(bclk_o), 64'(1));
        @(negedge clk);
        check({tag, "_lrck_left"},   64'(lrck_o), 64'(0));
        check({tag, "_bclk_fall"},   64'(bclk_o), 64'(0));
    endtask

    initial begin
        rst_ni   = 1'b0;
        en_i     = 1'b0;
        tx_valid = 1'b0;
        tx_left  = '0;
        tx_right = '0;
        repeat (3) @(negedge clk);
        check_idle("rst");
        check("rst_tx_ready", 64'(tx_ready_o), 64'(1));
        check("rst_sipo_wren", 64'(sipo_wren_o), 64'(0));

        rst_ni = 1'b1;
        repeat (4) @(negedge clk);
        check_idle("stopped");

        // Frame 1 prefilled, frame 2 starved
        push_pair(16'hA5C3, 16'h1234);
        exp_frame(16'hA5C3, 16'h1234, 0);
        en_i = 1'b1;
        check_first_fall("start");
        exp_frame('0, '0, 1);
        wait_lrck(1'b0, "f2_start");

        // Frames 3..6 with tx_valid held high
        wait_lrck(1'b0, "f3_start");
        tx_left  = 16'h0F0F;
        tx_right = 16'hF00D;
        tx_valid = 1'b1;
        repeat (4) exp_frame(16'h0F0F, 16'hF00D, 0);
        wait_lrck(1'b0, "f4_start");
        hs_cnt  = 0;
        rdy_cnt = 0;
        wait_lrck(1'b0, "f5_start");
        check("f4_handshakes", 64'(hs_cnt), 64'(1));
        check("f4_ready_cycles", 64'(rdy_cnt), 64'(1));
        hs_cnt  = 0;
        rdy_cnt = 0;
        wait_lrck(1'b0, "f6_start");
        check("f5_handshakes", 64'(hs_cnt), 64'(1));
        check("f5_ready_cycles", 64'(rdy_cnt), 64'(1));
        check("f6_buffer_full", 64'(tx_ready_o), 64'(0));
        tx_valid = 1'b0;
        exp_frame('0, '0, 1);

        // Frame 7: refill, then stop mid right slot
        wait_lrck(1'b0, "f7_start");
        wait_lrck(1'b1, "f7_right");
        push_pair(16'h8001, 16'h7FFE);
        repeat (36) @(negedge clk);
        en_i = 1'b0;
        exp_dac.delete();
        exp_rx.delete();
        repeat (3) @(negedge clk);
        check_idle("en_low");
        check("en_low_sipo_wren", 64'(sipo_wren_o), 64'(0));
        check("en_low_buffer_kept", 64'(tx_ready_o), 64'(0));
        exp_frame(16'h8001, 16'h7FFE, 0);
        exp_ur.push_back(1);
        repeat (20) @(negedge clk);
        check("en_low_buffer_still_kept", 64'(tx_ready_o), 64'(0));

        // Frame 8 after restart, then reset between the frame 9 load and first shift
        en_i = 1'b1;
        check_first_fall("restart");
        wait_lrck(1'b0, "f9_start");
        begin
            bit ok;
            ok = 0;
            for (int n = 0; n < 64; n++) begin
                @(negedge clk);
                if (piso_en_o && piso_wren_o == PISO_LOAD) begin
                    ok = 1;
                    break;
                end
            end
            check("f9_load_seen", 64'(ok), 64'(1));
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst_ni = 1'b0;
        #1;
        check_idle("async_rst");
        check("async_rst_tx_ready", 64'(tx_ready_o), 64'(1));
        repeat (2) @(negedge clk);

        check("dac_queue_drained", 64'(exp_dac.size()), 64'(0));
        check("rx_queue_drained", 64'(exp_rx.size()), 64'(0));
        check("underrun_queue_drained", 64'(exp_ur.size()), 64'(0));
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
